// File: rtl/hidden_cpu_prog_feeder.sv
// hidden_cpu_prog_feeder
// Program buffer that captures a short stream of 6-bit instruction words
// ({opcode[1:0], addrs[3:0]}) and then plays them back to the core over a
// valid/ready handshake. Playback can be redirected with jump_valid, and
// out-of-range jumps latch a sticky jump_err flag.
//
// Build option:
//   FEEDER_LOOP_EN  - defined: playback wraps from the last word back to
//                     word 0 and stays in RUN forever (DONE unreachable).
//                     undefined (default): the handshake on the last word
//                     moves to DONE.
module hidden_cpu_prog_feeder #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    input  logic [5:0]                 load_data,
    output logic                       load_ready,
    input  logic                       run,
    input  logic                       clear,
    input  logic                       jump_valid,
    input  logic [$clog2(DEPTH)-1:0]   jump_target,
    output logic                       instr_valid,
    output logic [5:0]                 instr_out,
    input  logic                       instr_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       jump_err,
    output logic [7:0]                 issued_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Count needs one extra bit so that a full buffer (count == DEPTH) is
    // representable.
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state;
    logic [AW:0]   count;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    issued;
    logic          jerr;
    logic [5:0]    mem [DEPTH];

    logic          load_hs;
    logic          at_last;
    logic          jump_ok;
    logic          has_prog;

    // Decode the handshakes and playback conditions for this cycle.
    always_comb begin
        load_hs  = (state == ST_LOAD) && load_valid && (count < CNT_FULL);
        at_last  = ({1'b0, rd_ptr} == (count - 1'b1));
        jump_ok  = ({1'b0, jump_target} < count);
        // A word accepted in the same cycle as run counts toward a
        // non-empty program, so run with a coincident first load starts.
        has_prog = (count != '0) || load_hs;
    end

    // Program storage: written only by accepted load words, never reset.
    always_ff @(posedge clk) begin
        if (load_hs && !clear) begin
            mem[count[AW-1:0]] <= load_data;
        end
    end

    // Control state, pointers, issue counter and sticky jump error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_LOAD;
            count  <= '0;
            rd_ptr <= '0;
            issued <= '0;
            jerr   <= 1'b0;
        end else if (clear) begin
            state  <= ST_LOAD;
            count  <= '0;
            rd_ptr <= '0;
            issued <= '0;
            jerr   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_hs) begin
                        count <= count + 1'b1;
                    end
                    if (run && has_prog) begin
                        state  <= ST_RUN;
                        rd_ptr <= '0;
                    end
                end
                ST_RUN: begin
                    if (instr_ready && (issued != 8'hFF)) begin
                        issued <= issued + 1'b1;
                    end
                    // A jump overrides the handshake advance; an
                    // out-of-range jump also holds rd_ptr where it is.
                    if (jump_valid) begin
                        if (jump_ok) begin
                            rd_ptr <= jump_target;
                        end else begin
                            jerr <= 1'b1;
                        end
                    end else if (instr_ready) begin
                        if (at_last) begin
`ifdef FEEDER_LOOP_EN
                            rd_ptr <= '0;
`else
                            state  <= ST_DONE;
`endif
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (run) begin
                        state  <= ST_RUN;
                        rd_ptr <= '0;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Outputs decode directly from state so reset clears them without a clock.
    always_comb begin
        instr_valid = (state == ST_RUN);
        instr_out   = (state == ST_RUN) ? mem[rd_ptr] : '0;
        busy        = (state == ST_RUN);
        done        = (state == ST_DONE);
        load_ready  = (state == ST_LOAD) && (count < CNT_FULL);
        jump_err    = jerr;
        issued_cnt  = issued;
    end

endmodule
